demux_route: RTL

Registered 1-to-3 demultiplexer with valid/ready flow control: it accepts one data beat at a time and delivers it to one of three output ports. The port is chosen by prioritized select lines, `sel1` > `sel2` > `sel3`. It is the distribution-side counterpart of the team's priority-select mux and sits between a single producer and three independent consumers. Each output port has its own one-entry holding register, so a stalled consumer blocks only the beats routed to it. Beats that carry no select are dropped and counted.

---
 rtl/demux_route.sv | 81 ++++++++
 1 files changed

// File: rtl/demux_route.sv
// Registered 1-to-3 demultiplexer with a one-entry holding register per output
// port and a saturating counter of beats accepted with no select asserted.
module demux_route #(
  parameter int DW   = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            sel1,
  input  logic            sel2,
  input  logic            sel3,
  output logic [DW-1:0]   op1,
  output logic [DW-1:0]   op2,
  output logic [DW-1:0]   op3,
  output logic            op_valid1,
  output logic            op_valid2,
  output logic            op_valid3,
  input  logic            op_ready1,
  input  logic            op_ready2,
  input  logic            op_ready3,
  output logic [CNTW-1:0] drop_cnt
);

  // Handshake: a beat moves on any interface when valid && ready are both high
  // at a rising edge; in_ready never looks at in_valid, and an output's valid
  // and payload stay stable while it waits for its ready.

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = 1;

  logic [DW-1:0]   data_q [3];
  logic [DW-1:0]   data_d [3];
  logic [2:0]      vld_q, vld_d;
  logic [2:0]      rdy, tgt, free, load;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            accept, drop;

  always_comb begin
    rdy = {op_ready3, op_ready2, op_ready1};
    tgt = 3'b000;
    if (sel1)      tgt = 3'b001;
    else if (sel2) tgt = 3'b010;
    else if (sel3) tgt = 3'b100;
    // A port can take a beat when empty or when it is draining this cycle.
    free     = ~vld_q | rdy;
    in_ready = (tgt == 3'b000) ? 1'b1 : |(tgt & free);
    accept   = in_valid && in_ready;
    load     = accept ? tgt : 3'b000;
    drop     = accept && (tgt == 3'b000);
    vld_d    = load | (vld_q & ~rdy);
    for (int k = 0; k < 3; k++) begin
      data_d[k] = load[k] ? in_data : data_q[k];
    end
    cnt_d = cnt_q;
    if (drop && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) data_q[k] <= '0;
      vld_q <= 3'b000;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) data_q[k] <= data_d[k];
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign op1       = data_q[0];
  assign op2       = data_q[1];
  assign op3       = data_q[2];
  assign op_valid1 = vld_q[0];
  assign op_valid2 = vld_q[1];
  assign op_valid3 = vld_q[2];
  assign drop_cnt  = cnt_q;

endmodule
